// File: rtl/display_digit_scheduler_pkg.sv
// Shared constants for the display digit scheduler: slot map, edit-field codes,
// FSM encoding and the helper that turns an edit field into its two-slot mask.
package display_digit_scheduler_pkg;

  localparam int NUM_DIGITS = 18;
  localparam int DIGIT_W    = 4;

  localparam int SLOT_DAY_T   = 0;
  localparam int SLOT_DAY_U   = 1;
  localparam int SLOT_MON_T   = 2;
  localparam int SLOT_MON_U   = 3;
  localparam int SLOT_YEAR_T  = 4;
  localparam int SLOT_YEAR_U  = 5;
  localparam int SLOT_HOUR_T  = 6;
  localparam int SLOT_HOUR_U  = 7;
  localparam int SLOT_MIN_T   = 8;
  localparam int SLOT_MIN_U   = 9;
  localparam int SLOT_SEC_T   = 10;
  localparam int SLOT_SEC_U   = 11;
  localparam int SLOT_THOUR_T = 12;
  localparam int SLOT_THOUR_U = 13;
  localparam int SLOT_TMIN_T  = 14;
  localparam int SLOT_TMIN_U  = 15;
  localparam int SLOT_TSEC_T  = 16;
  localparam int SLOT_TSEC_U  = 17;

  localparam logic [3:0] FIELD_NONE  = 4'd0;
  localparam logic [3:0] FIELD_DAY   = 4'd1;
  localparam logic [3:0] FIELD_MONTH = 4'd2;
  localparam logic [3:0] FIELD_YEAR  = 4'd3;
  localparam logic [3:0] FIELD_HOUR  = 4'd4;
  localparam logic [3:0] FIELD_MIN   = 4'd5;
  localparam logic [3:0] FIELD_SEC   = 4'd6;
  localparam logic [3:0] FIELD_THOUR = 4'd7;
  localparam logic [3:0] FIELD_TMIN  = 4'd8;
  localparam logic [3:0] FIELD_TSEC  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PENDING = 2'd2,
    ST_COMMIT  = 2'd3
  } state_e;

  // Field k (1-based) owns the tens/units pair at slots 2(k-1) and 2(k-1)+1.
  function automatic logic [NUM_DIGITS-1:0] field_mask(input logic [3:0] field);
    logic [NUM_DIGITS-1:0] m;
    m = '0;
    if (field != FIELD_NONE && field <= FIELD_TSEC)
      m = NUM_DIGITS'(3) << (2 * (int'(field) - 1));
    return m;
  endfunction

endpackage

// File: rtl/display_digit_scheduler_blink_timer.sv
// Frame counter driven by vsync ticks; toggles blink_phase every BLINK_FRAMES frames.
module blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic vsync_tick,
  output logic blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (vsync_tick) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_digit_scheduler.sv
// Double-buffered BCD digit bank for the VGA text generator: writes land in a
// shadow bank and reach the display only at vertical blanking; also drives blink masks.
module display_digit_scheduler
  import display_digit_scheduler_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [4:0]                    wr_idx,
  input  logic [DIGIT_W-1:0]            wr_digit,
  input  logic                          wr_last,
  input  logic                          vsync_tick,
  input  logic [3:0]                    edit_field,
  input  logic                          alarm_armed,
  input  logic                          alarm_ringing,
  output logic [NUM_DIGITS*DIGIT_W-1:0] disp_digits,
  output logic [NUM_DIGITS-1:0]         blank_mask,
  output logic                          symbol_on,
  output logic                          commit_done,
  output logic                          wr_err
);

  state_e state_q, state_d;
  logic   run_q;
  logic   blink_phase;
  logic   wr_acc;
  logic   wr_ok;

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] shadow;

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_timer (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .vsync_tick (vsync_tick),
    .blink_phase(blink_phase)
  );

  assign wr_acc = wr_valid && wr_ready;
  assign wr_ok  = (wr_idx <= 5'(SLOT_TSEC_U)) && (wr_digit <= 4'd9);

  // run_q holds wr_ready low for the whole reset assertion and releases on the first clock.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        wr_ready = run_q;
        if (wr_valid && run_q)
          state_d = wr_last ? ST_PENDING : ST_LOAD;
      end
      ST_PENDING: begin
        if (vsync_tick)
          state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Invalid writes still advance the FSM but never touch the shadow bank.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow      <= '0;
      disp_digits <= '0;
      commit_done <= 1'b0;
      wr_err      <= 1'b0;
      blank_mask  <= '0;
      symbol_on   <= 1'b0;
    end else begin
      commit_done <= (state_q == ST_COMMIT);
      if (wr_acc && wr_ok)
        shadow[wr_idx] <= wr_digit;
      if (state_q == ST_COMMIT) begin
        disp_digits <= shadow;
        wr_err      <= 1'b0;
      end else if (wr_acc && !wr_ok) begin
        wr_err <= 1'b1;
      end
      blank_mask <= field_mask(edit_field) & {NUM_DIGITS{blink_phase}};
      symbol_on  <= alarm_ringing ? blink_phase : alarm_armed;
    end
  end

endmodule

// File: tb/tb_display_digit_scheduler.sv
// Randomized scoreboard bench for display_digit_scheduler with a frame-level reference model.
module tb_display_digit_scheduler;

  localparam int BF = 2;

  logic        CLK;
  logic        RST_N;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_idx;
  logic [3:0]  wr_digit;
  logic        wr_last;
  logic        vsync_tick;
  logic [3:0]  edit_field;
  logic        alarm_armed;
  logic        alarm_ringing;
  logic [71:0] disp_digits;
  logic [17:0] blank_mask;
  logic        symbol_on;
  logic        commit_done;
  logic        wr_err;

  display_digit_scheduler #(
    .BLINK_FRAMES(BF)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_idx       (wr_idx),
    .wr_digit     (wr_digit),
    .wr_last      (wr_last),
    .vsync_tick   (vsync_tick),
    .edit_field   (edit_field),
    .alarm_armed  (alarm_armed),
    .alarm_ringing(alarm_ringing),
    .disp_digits  (disp_digits),
    .blank_mask   (blank_mask),
    .symbol_on    (symbol_on),
    .commit_done  (commit_done),
    .wr_err       (wr_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: digit arrays, a burst-complete flag, a sticky error and a tick count.
  int          model_shadow [18];
  logic [71:0] model_disp;
  bit          pending;
  bit          model_err;
  int          ticks;
  logic [71:0] exp_q [$];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp_v);
    end
  endtask

  function automatic logic [71:0] pack_shadow();
    logic [71:0] r;
    r = '0;
    for (int i = 0; i < 18; i++) r[4*i +: 4] = 4'(model_shadow[i]);
    return r;
  endfunction

  function automatic bit phase_now();
    return ((ticks / BF) % 2) == 1;
  endfunction

  function automatic logic [17:0] exp_blank(input int f);
    logic [17:0] m;
    m = '0;
    if (f >= 1 && f <= 9 && phase_now()) begin
      m[2*(f-1)]     = 1'b1;
      m[2*(f-1) + 1] = 1'b1;
    end
    return m;
  endfunction

  always @(negedge CLK) begin
    if (RST_N === 1'b1 && commit_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit actual=%0h expected=no_commit", disp_digits);
      end else begin
        logic [71:0] e;
        e = exp_q.pop_front();
        check("commit_disp", disp_digits, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (wr_ready !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    if (wr_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wr_ready_timeout actual=%b expected=1", wr_ready);
    end
  endtask

  task automatic do_write(input int idx, input int dig, input bit last, input bit with_tick);
    wait_ready();
    wr_valid   = 1'b1;
    wr_idx     = 5'(idx);
    wr_digit   = 4'(dig);
    wr_last    = last;
    vsync_tick = with_tick;
    cyc();
    wr_valid   = 1'b0;
    wr_last    = 1'b0;
    vsync_tick = 1'b0;
    if (with_tick) ticks++;
    if (idx <= 17 && dig <= 9) model_shadow[idx] = dig;
    else model_err = 1'b1;
    if (last) pending = 1'b1;
  endtask

  task automatic vsync();
    bit commit_now;
    commit_now = pending;
    vsync_tick = 1'b1;
    cyc();
    vsync_tick = 1'b0;
    ticks++;
    if (commit_now) begin
      pending = 1'b0;
      check1("latency_no_pulse_yet", commit_done, 1'b0);
      check("latency_disp_held", disp_digits, model_disp);
      model_disp = pack_shadow();
      model_err  = 1'b0;
      exp_q.push_back(model_disp);
      cyc();
      check1("commit_pulse", commit_done, 1'b1);
      check1("wr_err_cleared", wr_err, 1'b0);
    end
  endtask

  task automatic check_outputs();
    cyc();
    check("blank_mask", 72'(blank_mask), 72'(exp_blank(int'(edit_field))));
    check1("symbol_on", symbol_on,
           alarm_ringing ? logic'(phase_now()) : alarm_armed);
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    wr_valid = 1'b0; wr_last = 1'b0; vsync_tick = 1'b0;
    #2;
    for (int i = 0; i < 18; i++) model_shadow[i] = 0;
    model_disp = '0;
    pending    = 1'b0;
    model_err  = 1'b0;
    ticks      = 0;
    check("rst_disp", disp_digits, 72'(0));
    check("rst_blank", 72'(blank_mask), 72'(0));
    check1("rst_symbol", symbol_on, 1'b0);
    check1("rst_commit_done", commit_done, 1'b0);
    check1("rst_wr_err", wr_err, 1'b0);
    check1("rst_wr_ready", wr_ready, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc();
    check1("post_rst_wr_ready", wr_ready, 1'b1);
  endtask

  int vals [18] = '{1,2,0,9,2,4,1,3,4,5,5,9,0,0,1,0,3,0};

  initial begin
    RST_N = 1'b1;
    wr_valid = 1'b0; wr_idx = '0; wr_digit = '0; wr_last = 1'b0;
    vsync_tick = 1'b0; edit_field = '0; alarm_armed = 1'b0; alarm_ringing = 1'b0;
    #3;
    apply_reset();

    // Full 18-slot burst, held until vsync.
    for (int i = 0; i < 18; i++) do_write(i, vals[i], i == 17, 1'b0);
    repeat (3) cyc();
    check("held_before_vsync", disp_digits, 72'(0));
    check1("pending_not_ready", wr_ready, 1'b0);
    vsync();
    check("slot3_is_9", 72'(disp_digits[15:12]), 72'(9));
    check("slot11_is_9", 72'(disp_digits[47:44]), 72'(9));

    // Partial burst straddling a vsync never reaches the display.
    do_write(0, 7, 1'b0, 1'b0);
    do_write(1, 8, 1'b0, 1'b0);
    vsync();
    cyc();
    check("partial_not_shown", disp_digits, model_disp);
    do_write(2, 6, 1'b1, 1'b0);
    vsync();

    // Invalid index and invalid digit.
    do_write(20, 5, 1'b0, 1'b0);
    check1("wr_err_bad_idx", wr_err, 1'b1);
    do_write(3, 12, 1'b1, 1'b0);
    check1("wr_err_sticky", wr_err, 1'b1);
    check1("invalid_last_pending", wr_ready, 1'b0);
    vsync();

    // wr_last coinciding with vsync does not commit on that tick.
    do_write(4, 3, 1'b0, 1'b0);
    do_write(5, 1, 1'b1, 1'b1);
    cyc();
    cyc();
    check1("same_tick_no_commit", commit_done, 1'b0);
    check("same_tick_disp_held", disp_digits, model_disp);
    vsync();

    // Randomized bursts with stray vsyncs, invalid writes and idle gaps.
    for (int b = 0; b < 25; b++) begin
      int len;
      len = int'($urandom_range(1, 5));
      for (int k = 0; k < len; k++) begin
        int idx, dig;
        idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(18, 31)) : int'($urandom_range(0, 17));
        dig = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
        repeat ($urandom_range(0, 2)) cyc();
        if (k < len - 1 && $urandom_range(0, 3) == 0) vsync();
        do_write(idx, dig, k == len - 1, 1'b0);
      end
      check1("rand_wr_err", wr_err, model_err);
      repeat ($urandom_range(0, 3)) cyc();
      vsync();
    end

    // Blink masking on the minutes field.
    edit_field = 4'd5;
    check_outputs();
    for (int i = 0; i < 8; i++) begin
      vsync();
      check_outputs();
    end
    for (int i = 0; i < 6; i++) begin
      edit_field = 4'($urandom_range(0, 15));
      if (i % 2 == 0) vsync();
      check_outputs();
    end
    edit_field = 4'd0;
    check_outputs();

    // Alarm symbol: steady when armed, blinking when ringing.
    alarm_armed = 1'b1;
    check_outputs();
    alarm_ringing = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vsync();
      check_outputs();
    end
    alarm_armed = 1'b0;
    alarm_ringing = 1'b0;
    check_outputs();

    // Reset while a committed-pending burst waits for vsync.
    do_write(6, 4, 1'b0, 1'b0);
    do_write(7, 2, 1'b1, 1'b0);
    check1("pre_reset_pending", wr_ready, 1'b0);
    #2;
    apply_reset();
    vsync();
    cyc();
    check("post_rst_no_commit", disp_digits, 72'(0));
    do_write(9, 5, 1'b1, 1'b0);
    vsync();

    repeat (4) cyc();
    check("scoreboard_drained", 72'(exp_q.size()), 72'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_digit_scheduler.md
Name: display_digit_scheduler

Overview:
- Sits between the RTC read/edit logic and the VGA text generator.
- Accepts BCD digit updates over a valid/ready write port into a shadow bank.
- Commits the shadow bank to the displayed bank only at the start of vertical blanking, so date, time and timer digits never tear mid-frame.
- Also generates frame-based blink masking for the field being edited and the on/off control for the alarm symbol.

Parameters:
- NUM_DIGITS, 18, digit slots: date DD MM AA, time HH MM SS, timer HH MM SS; two digits per field.
- DIGIT_W, 4, bits per BCD digit.
- BLINK_FRAMES, 30, vsync ticks per blink half-period.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- wr_valid  in  1  digit write request
- wr_ready  out  1  write port can accept
- wr_idx  in  5  digit slot, 0..17; slot 2k = tens, 2k+1 = units of field k+1
- wr_digit  in  4  BCD value
- wr_last  in  1  marks final write of an update burst
- vsync_tick  in  1  one-cycle pulse at start of vertical blanking
- edit_field  in  4  0 = none; 1..9 = day, month, year, hour, min, sec, t_hour, t_min, t_sec
- alarm_armed  in  1  alarm enabled
- alarm_ringing  in  1  alarm firing
- disp_digits  out  72  displayed bank; slot i occupies bits [4i+3:4i]
- blank_mask  out  18  1 = generator draws a blank in place of slot i
- symbol_on  out  1  draw alarm symbol
- commit_done  out  1  one-cycle pulse when the shadow bank is copied to the displayed bank
- wr_err  out  1  sticky: an invalid write was dropped

Behaviour:
- Reset (async, RST_N=0):
  - disp_digits, shadow bank, blank_mask, commit_done, wr_err, frame counter and blink_phase all = 0.
  - symbol_on = 0; state = IDLE; wr_ready = 0 while in reset.
- FSM states:
  - IDLE: wr_ready=1. An accepted write goes to LOAD, or to PENDING if wr_last=1.
  - LOAD: wr_ready=1. Each accepted write updates the shadow slot. An accepted write with wr_last=1 goes to PENDING.
  - PENDING: wr_ready=0. On vsync_tick, go to COMMIT.
  - COMMIT: one cycle. Copy shadow to disp_digits, pulse commit_done, clear wr_err, return to IDLE.
- A write is accepted when wr_valid && wr_ready. The shadow updates on that edge; disp_digits is unaffected until COMMIT.
- Invalid write (wr_idx>17 or wr_digit>9):
  - Still accepted and still advances the FSM (wr_last honoured).
  - Data dropped; wr_err set the next cycle.
- vsync_tick during IDLE or LOAD: no commit; a partial burst never reaches the display.
- wr_last accepted in the same cycle as vsync_tick: that tick is not used; commit waits for the next tick (≥1 frame latency).
- Commit latency: disp_digits updates 2 cycles after the vsync_tick edge in PENDING (enter COMMIT, then register).
- Unwritten slots keep their previous shadow value; the shadow is not cleared after commit.
- Blink:
  - frame_cnt increments on each vsync_tick.
  - At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- blank_mask (registered, 1-cycle latency from inputs):
  - Bits 2(f-1) and 2(f-1)+1 are set when edit_field=f∈1..9 and blink_phase=1.
  - All zero when edit_field=0 or edit_field>9.
- symbol_on (registered):
  - alarm_ringing=1 → blink_phase.
  - Otherwise alarm_armed=1 → 1.
  - Otherwise 0.
- Reset mid-burst: shadow and display return to zeros, so the display reads 00/00/00 00:00:00 00:00:00.

Decomposition:
- Shared package:
  - Slot index constants (SLOT_DAY_T … SLOT_TSEC_U) and field codes (FIELD_NONE=0 … FIELD_TSEC=9).
  - FSM state encoding (IDLE, LOAD, PENDING, COMMIT).
  - NUM_DIGITS and DIGIT_W.
- One sub-module, blink_timer: frame counter, blink_phase, BLINK_FRAMES parameter.

Test Plan:
- Reset, then write slots 0..17 with values 1,2,0,9,2,4,1,3,4,5,5,9,0,0,1,0,3,0 (last with wr_last), no vsync → disp_digits stays 0, wr_ready=0; pulse vsync_tick → commit_done one cycle, disp_digits slot 3 = 9, slot 11 = 9.
- Burst of 2 writes interrupted by vsync_tick before wr_last → disp_digits unchanged; after wr_last and the next vsync_tick → new values shown.
- wr_idx=20, then wr_digit=12 with wr_last → both accepted, wr_err=1, shadow unchanged; after commit → wr_err=0.
- edit_field=5 with BLINK_FRAMES=2, 8 vsync_ticks → blank_mask toggles between 0 and 18'h00300 every 2 ticks; edit_field=0 → mask 0.
- alarm_armed=1 → symbol_on=1 steady; alarm_ringing=1 → symbol_on follows blink_phase.
- RST_N low while in PENDING → all outputs 0, state IDLE; wr_ready=1 after release.
